// File: rtl/gcd_pkg.sv
// Shared FSM state encoding and algorithm-select constants for the GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } gcd_state_e;

    localparam int GCD_ALGO_SUB = 0;
    localparam int GCD_ALGO_BIN = 1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: subtractive Euclid or binary (Stein) step.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ALGO  = GCD_ALGO_SUB,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [KW-1:0]    k_o,
    output logic             eq_o
);

    localparam bit BIN = (ALGO == GCD_ALGO_BIN);

    always_comb begin
        a_o  = a_i;
        b_o  = b_i;
        k_o  = k_i;
        eq_o = (a_i == b_i);
        // Equal operands are the finish condition, so nothing moves that cycle.
        if (!eq_o) begin
            if (BIN && !a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1;
                b_o = b_i >> 1;
                k_o = k_i + 1'b1;
            end else if (BIN && !a_i[0]) begin
                a_o = a_i >> 1;
            end else if (BIN && !b_i[0]) begin
                b_o = b_i >> 1;
            end else if (a_i > b_i) begin
                a_o = a_i - b_i;
            end else begin
                b_o = b_i - a_i;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine with valid/ready handshakes, one operation in flight.
// Define GCD_CYCLE_COUNT_EN to add the out_cycles COMPUTE-cycle counter port.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ALGO  = GCD_ALGO_SUB,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_cycles
`endif
);

    localparam int KW = $clog2(WIDTH) + 1;

    gcd_state_e       state_q;
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             eq;

    gcd_step #(.WIDTH(WIDTH), .ALGO(ALGO), .KW(KW)) u_step (
        .a_i (a_q),
        .b_i (b_q),
        .k_i (k_q),
        .a_o (a_d),
        .b_o (b_d),
        .k_o (k_d),
        .eq_o(eq)
    );

`ifndef GCD_CYCLE_COUNT_EN
    logic cnt_w_unused;
    assign cnt_w_unused = |CNT_W;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_gcd   <= '0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
            out_cycles <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        k_q      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef GCD_CYCLE_COUNT_EN
                        out_cycles <= '0;
`endif
                        // A zero operand makes the other one the answer.
                        if (in_a == '0 || in_b == '0) begin
                            out_gcd   <= in_a | in_b;
                            out_err   <= (in_a == '0) && (in_b == '0);
                            out_valid <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q <= ST_COMPUTE;
                        end
                    end
                end
                ST_COMPUTE: begin
`ifdef GCD_CYCLE_COUNT_EN
                    if (out_cycles != '1) out_cycles <= out_cycles + 1'b1;
`endif
                    if (eq) begin
                        // Truncation is exact: the result never exceeds either operand.
                        out_gcd   <= a_q << k_q;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        a_q <= a_d;
                        b_q <= b_d;
                        k_q <= k_d;
                    end
                end
                ST_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Randomized self-checking bench for gcd_engine: subtractive, binary and narrow instances.
module tb_gcd_engine;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0]       iv, ir, ov, ordy, oe, bz;
    logic [2:0][15:0] ia, ib, og, oc;
    logic [7:0]       og8;
    logic [3:0]       oc8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_W(16)) u_sub (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_gcd(og[0]), .out_err(oe[0]), .busy(bz[0])
`ifdef GCD_CYCLE_COUNT_EN
        , .out_cycles(oc[0])
`endif
    );

    gcd_engine #(.WIDTH(16), .ALGO(1), .CNT_W(16)) u_bin (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_gcd(og[1]), .out_err(oe[1]), .busy(bz[1])
`ifdef GCD_CYCLE_COUNT_EN
        , .out_cycles(oc[1])
`endif
    );

    gcd_engine #(.WIDTH(8), .ALGO(0), .CNT_W(4)) u_w8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(ia[2][7:0]), .in_b(ib[2][7:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_gcd(og8), .out_err(oe[2]), .busy(bz[2])
`ifdef GCD_CYCLE_COUNT_EN
        , .out_cycles(oc8)
`endif
    );

    assign og[2] = {8'd0, og8};
`ifdef GCD_CYCLE_COUNT_EN
    assign oc[2] = {12'd0, oc8};
`else
    assign oc    = '0;
    assign oc8   = '0;
`endif

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        if (a == 0) return b;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractions Euclid needs before the operands meet (nonzero inputs).
    function automatic int ref_subs(input int a, input int b);
        int n = 0;
        while (a != b) begin
            if (a > b) a -= b; else b -= a;
            n++;
        end
        return n;
    endfunction

    // Issue one operand pair, wait for the result, optionally hold off out_ready.
    task automatic run(input int idx, input int a, input int b, input int hold,
                       output int g, output int e, output int lat, output int cyc);
        int exp_g;
        exp_g = ref_gcd(a, b);
        @(negedge clk);
        ia[idx] = a[15:0];
        ib[idx] = b[15:0];
        iv[idx] = 1'b1;
        chk("in_ready_idle", ir[idx], 1);
        @(posedge clk);
        #1 iv[idx] = 1'b0;
        lat = 0;
        while (!ov[idx] && lat < 70000) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("out_valid_seen", ov[idx], 1);
        g   = og[idx];
        e   = oe[idx];
        cyc = oc[idx];
        for (int i = 0; i < hold; i++) begin
            ia[idx] = 16'd99;
            ib[idx] = 16'd33;
            iv[idx] = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_valid", ov[idx], 1);
            chk("bp_gcd", og[idx], exp_g);
            chk("bp_in_ready", ir[idx], 0);
            chk("bp_busy", bz[idx], 1);
        end
        iv[idx]   = 1'b0;
        ordy[idx] = 1'b1;
        @(posedge clk);
        #1 ordy[idx] = 1'b0;
        chk("rel_in_ready", ir[idx], 1);
        chk("rel_valid", ov[idx], 0);
        chk("rel_busy", bz[idx], 0);
    endtask

    initial begin
        int g, e, lat, cyc, a, b;
        iv = '0; ordy = '0; ia = '0; ib = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ir, 3'b111);
        chk("rst_valid", ov, 0);
        chk("rst_gcd", og, 0);
        chk("rst_err", oe, 0);
        chk("rst_busy", bz, 0);
        @(negedge clk) reset_n = 1'b1;

        run(0, 48, 18, 0, g, e, lat, cyc);
        chk("sub48_18_gcd", g, 6);
        chk("sub48_18_lat", lat, 5);
`ifdef GCD_CYCLE_COUNT_EN
        chk("sub48_18_cyc", cyc, 5);
`endif
        run(1, 48, 18, 0, g, e, lat, cyc);
        chk("bin48_18_gcd", g, 6);
        chk("bin48_18_lat", lat, 7);
`ifdef GCD_CYCLE_COUNT_EN
        chk("bin48_18_cyc", cyc, 7);
`endif

        run(0, 0, 35, 0, g, e, lat, cyc);
        chk("z0_35_gcd", g, 35); chk("z0_35_err", e, 0); chk("z0_35_lat", lat, 0);
`ifdef GCD_CYCLE_COUNT_EN
        chk("z0_35_cyc", cyc, 0);
`endif
        run(0, 0, 0, 0, g, e, lat, cyc);
        chk("z0_0_gcd", g, 0); chk("z0_0_err", e, 1); chk("z0_0_lat", lat, 0);
        run(1, 35, 0, 0, g, e, lat, cyc);
        chk("z35_0_gcd", g, 35); chk("z35_0_err", e, 0); chk("z35_0_lat", lat, 0);

        run(0, 12, 8, 10, g, e, lat, cyc);
        chk("bp12_8_gcd", g, 4);
        run(0, 9, 6, 0, g, e, lat, cyc);
        chk("after_bp_gcd", g, 3);

        // Reset in the middle of a long subtractive run.
        @(negedge clk);
        ia[2] = 16'd255; ib[2] = 16'd1; iv[2] = 1'b1;
        @(posedge clk);
        #1 iv[2] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midop_busy", bz[2], 1);
        chk("midop_valid", ov[2], 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_ready", ir[2], 1);
        chk("abort_valid", ov[2], 0);
        chk("abort_busy", bz[2], 0);
        reset_n = 1'b1;

        run(2, 255, 1, 0, g, e, lat, cyc);
        chk("w8_255_1_gcd", g, 1);
        chk("w8_255_1_lat", lat, 255);
`ifdef GCD_CYCLE_COUNT_EN
        chk("w8_255_1_cyc_sat", cyc, 15);
`endif
        run(2, 255, 255, 0, g, e, lat, cyc);
        chk("w8_255_255_gcd", g, 255);
        chk("w8_255_255_lat", lat, 1);
`ifdef GCD_CYCLE_COUNT_EN
        chk("w8_255_255_cyc", cyc, 1);
`endif
        run(1, 128, 64, 0, g, e, lat, cyc);
        chk("bin128_64_gcd", g, 64);
        run(1, 65535, 65535, 0, g, e, lat, cyc);
        chk("bin_max_gcd", g, 65535);

        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1500));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1500));
            run(0, a, b, 0, g, e, lat, cyc);
            chk("rnd_sub_gcd", g, ref_gcd(a, b));
            chk("rnd_sub_err", e, (a == 0 && b == 0) ? 1 : 0);
            chk("rnd_sub_lat", lat, (a == 0 || b == 0) ? 0 : ref_subs(a, b) + 1);
            run(1, a, b, 0, g, e, lat, cyc);
            chk("rnd_bin_small_gcd", g, ref_gcd(a, b));
            a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 65535));
            b = int'($urandom_range(0, 65535));
            run(1, a, b, 0, g, e, lat, cyc);
            chk("rnd_bin_gcd", g, ref_gcd(a, b));
            chk("rnd_bin_err", e, (a == 0 && b == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
